// File: rtl/dot_seq.sv
// dot_seq: sequences a dot product over two AXI-Stream element streams using
// an external single-cycle multiply-accumulate unit (a*b+c).
// Each element takes three cycles: ISSUE (accept a/b pair), PRES (present the
// operands to the MAC for one cycle), WAIT (take the MAC result into acc).
// Optional build macro DOT_SEQ_BIAS_EN adds a cfg_bias input that seeds the
// accumulator at start; without it the accumulator starts at zero.
module dot_seq #(
  parameter int BITWIDTH  = 32,
  parameter int LEN_WIDTH = 16
) (
  input  logic                 aclk,
  input  logic                 areset,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] cfg_len,
  output logic                 busy,
  input  logic [BITWIDTH-1:0]  s_axis_a_tdata,
  input  logic                 s_axis_a_tvalid,
  output logic                 s_axis_a_tready,
  input  logic [BITWIDTH-1:0]  s_axis_b_tdata,
  input  logic                 s_axis_b_tvalid,
  output logic                 s_axis_b_tready,
  output logic [BITWIDTH-1:0]  m_macc_a_tdata,
  output logic [BITWIDTH-1:0]  m_macc_b_tdata,
  output logic [BITWIDTH-1:0]  m_macc_c_tdata,
  output logic                 m_macc_tvalid,
  input  logic [BITWIDTH-1:0]  s_macc_result_tdata,
  input  logic                 s_macc_result_tvalid,
  output logic [BITWIDTH-1:0]  m_axis_dot_tdata,
  output logic                 m_axis_dot_tvalid,
  input  logic                 m_axis_dot_tready
`ifdef DOT_SEQ_BIAS_EN
  ,
  input  logic [BITWIDTH-1:0]  cfg_bias
`endif
);

  typedef enum logic [2:0] {IDLE, ISSUE, PRES, WAIT, DONE} state_t;

  state_t                 state_q, state_d;
  logic [LEN_WIDTH-1:0]   len_q, len_d;
  logic [LEN_WIDTH-1:0]   count_q, count_d;
  logic [BITWIDTH-1:0]    acc_q, acc_d;
  logic [BITWIDTH-1:0]    a_q, a_d;
  logic [BITWIDTH-1:0]    b_q, b_d;
  logic [BITWIDTH-1:0]    c_q, c_d;
  logic [BITWIDTH-1:0]    acc_init;
  logic                   xfer;

`ifdef DOT_SEQ_BIAS_EN
  assign acc_init = cfg_bias;
`else
  assign acc_init = '0;
`endif

  // Both streams move together: a pair is accepted only when both are valid.
  assign xfer            = (state_q == ISSUE) && s_axis_a_tvalid && s_axis_b_tvalid;
  // Handshake/status outputs are forced low while reset is held, whatever the state.
  assign s_axis_a_tready = !areset && xfer;
  assign s_axis_b_tready = !areset && xfer;
  assign busy            = !areset && (state_q != IDLE);
  assign m_macc_tvalid   = !areset && (state_q == PRES);
  assign m_axis_dot_tvalid = !areset && (state_q == DONE);
  assign m_axis_dot_tdata  = acc_q;
  // Operand buses read as zero whenever they are not being presented.
  assign m_macc_a_tdata  = m_macc_tvalid ? a_q : '0;
  assign m_macc_b_tdata  = m_macc_tvalid ? b_q : '0;
  assign m_macc_c_tdata  = m_macc_tvalid ? c_q : '0;

  // Next-state and datapath update; MAC results are only taken in WAIT.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    count_d = count_q;
    acc_d   = acc_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          len_d   = cfg_len;
          count_d = '0;
          acc_d   = acc_init;
          state_d = (cfg_len == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        if (xfer) begin
          a_d     = s_axis_a_tdata;
          b_d     = s_axis_b_tdata;
          c_d     = acc_q;
          state_d = PRES;
        end
      end
      PRES: begin
        a_d     = '0;
        b_d     = '0;
        c_d     = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (s_macc_result_tvalid) begin
          acc_d   = s_macc_result_tdata;
          count_d = count_q + LEN_WIDTH'(1);
          state_d = ((count_q + LEN_WIDTH'(1)) == len_q) ? DONE : ISSUE;
        end
      end
      DONE: begin
        if (m_axis_dot_tready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset clears everything, discarding any partial sum.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= IDLE;
      len_q   <= '0;
      count_q <= '0;
      acc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      count_q <= count_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
    end
  end

endmodule

// File: tb/tb_dot_seq.sv
// Testbench for dot_seq: directed vectors against an ideal one-cycle MAC model.
// Build with DOT_SEQ_BIAS_EN defined to exercise the bias input.
module tb_dot_seq;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] cfg_len = '0;
  logic        busy;
  logic [31:0] a_d = '0, b_d = '0;
  logic        a_v = 1'b0, b_v = 1'b0;
  logic        a_tready, b_tready;
  logic [31:0] mac_a, mac_b, mac_c;
  logic        m_macc_tvalid;
  logic [31:0] res_d = '0;
  logic        res_v = 1'b0;
  logic [31:0] dot_tdata;
  logic        dot_tvalid;
  logic        dot_tready = 1'b0;
  logic        inj = 1'b0;

`ifdef DOT_SEQ_BIAS_EN
  localparam logic [31:0] BIAS = 32'd100;
`else
  localparam logic [31:0] BIAS = 32'd0;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  dot_seq #(.BITWIDTH(32), .LEN_WIDTH(16)) dut (
    .aclk                 (aclk),
    .areset               (areset),
    .start                (start),
    .cfg_len              (cfg_len),
    .busy                 (busy),
    .s_axis_a_tdata       (a_d),
    .s_axis_a_tvalid      (a_v),
    .s_axis_a_tready      (a_tready),
    .s_axis_b_tdata       (b_d),
    .s_axis_b_tvalid      (b_v),
    .s_axis_b_tready      (b_tready),
    .m_macc_a_tdata       (mac_a),
    .m_macc_b_tdata       (mac_b),
    .m_macc_c_tdata       (mac_c),
    .m_macc_tvalid        (m_macc_tvalid),
    .s_macc_result_tdata  (res_d),
    .s_macc_result_tvalid (res_v),
    .m_axis_dot_tdata     (dot_tdata),
    .m_axis_dot_tvalid    (dot_tvalid),
    .m_axis_dot_tready    (dot_tready)
`ifdef DOT_SEQ_BIAS_EN
    ,
    .cfg_bias             (BIAS)
`endif
  );

  always #5 aclk = ~aclk;

  // Ideal MAC: result one cycle after tvalid; inj forces a stray junk result.
  always @(posedge aclk) begin
    res_v <= m_macc_tvalid | inj;
    res_d <= inj ? 32'hDEADBEEF : (mac_a * mac_b + mac_c);
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run_vec(input string tag, input int n,
                         input logic [31:0] av [4], input logic [31:0] bv [4],
                         input int gap_at, input int gap_len, input int hold,
                         input bit noise, input logic [31:0] exp, input int exp_lat);
    int i, cyc, mac, gap, alone;
    i = 0; cyc = 0; mac = 0; gap = 0; alone = 0;
    cfg_len = 16'(n);
    start = 1'b1;
    tick();
    cyc = 1;
    start = noise;
    if (noise) cfg_len = 16'd7;
    while (!dot_tvalid && cyc < 200) begin
      inj = 1'b0; a_v = 1'b0; b_v = 1'b0;
      if (i < n) begin
        a_d = av[i]; b_d = bv[i]; a_v = 1'b1; b_v = 1'b1;
        if (i == gap_at && gap < gap_len) begin
          b_v = 1'b0;
          if (gap == 3) inj = 1'b1;
          gap++;
        end
      end
      #1;
      if (a_tready && !b_v) alone++;
      if (a_tready) i++;
      if (m_macc_tvalid) mac++;
      tick();
      cyc++;
    end
    inj = 1'b0; a_v = 1'b0; b_v = 1'b0;
    chk({tag, "_vld"}, 64'(dot_tvalid), 64'd1);
    chk({tag, "_dot"}, 64'(dot_tdata), 64'(exp));
    if (exp_lat >= 0) chk({tag, "_lat"}, 64'(cyc), 64'(exp_lat));
    chk({tag, "_xfers"}, 64'(i), 64'(n));
    chk({tag, "_macc"}, 64'(mac), 64'(n));
    chk({tag, "_maczero"}, 64'(mac_a), 64'd0);
    if (gap_len > 0) chk({tag, "_alone"}, 64'(alone), 64'd0);
    for (int k = 0; k < hold; k++) begin
      tick();
      chk({tag, "_hold_vld"}, 64'(dot_tvalid), 64'd1);
      chk({tag, "_hold_dot"}, 64'(dot_tdata), 64'(exp));
    end
    dot_tready = 1'b1;
    tick();
    dot_tready = 1'b0;
    start = 1'b0;
    chk({tag, "_idle"}, 64'(busy), 64'd0);
    chk({tag, "_vld_off"}, 64'(dot_tvalid), 64'd0);
  endtask

  initial begin
    int cnt, cyc;
    // Reset with streams offering data: nothing may handshake.
    a_v = 1'b1; b_v = 1'b1; a_d = 32'd9; b_d = 32'd9;
    tick(); tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_atready", 64'(a_tready), 64'd0);
    chk("rst_btready", 64'(b_tready), 64'd0);
    chk("rst_macvld", 64'(m_macc_tvalid), 64'd0);
    chk("rst_dotvld", 64'(dot_tvalid), 64'd0);
    areset = 1'b0; a_v = 1'b0; b_v = 1'b0;
    tick();
    chk("rst_maca", 64'(mac_a), 64'd0);
    chk("rst_macc", 64'(mac_c), 64'd0);
    chk("rst_dot", 64'(dot_tdata), 64'd0);

    // 1*4 + 2*5 + 3*6 = 32
    run_vec("n3", 3, '{32'd1, 32'd2, 32'd3, 32'd0}, '{32'd4, 32'd5, 32'd6, 32'd0},
            -1, 0, 0, 1'b0, 32'd32 + BIAS, 10);
    // Empty vector: result is the initial accumulator one cycle after start
    run_vec("n0", 0, '{32'd0, 32'd0, 32'd0, 32'd0}, '{32'd0, 32'd0, 32'd0, 32'd0},
            -1, 0, 0, 1'b0, BIAS, 1);
    // b stalls 5 cycles before element 2, with a stray MAC result during ISSUE: 3*5+4*6 = 39
    run_vec("gap", 2, '{32'd3, 32'd4, 32'd0, 32'd0}, '{32'd5, 32'd6, 32'd0, 32'd0},
            1, 5, 0, 1'b0, 32'd39 + BIAS, -1);
    // (-1)*(-1) + 2*2 = 5 mod 2^32; result held 4 cycles under backpressure
    run_vec("wrap", 2, '{32'hFFFFFFFF, 32'd2, 32'd0, 32'd0}, '{32'hFFFFFFFF, 32'd2, 32'd0, 32'd0},
            -1, 0, 4, 1'b0, 32'd5 + BIAS, 7);
    // start held high through ISSUE/PRES/WAIT/DONE: 2*10 + 3*20 = 80
    run_vec("noise", 2, '{32'd2, 32'd3, 32'd0, 32'd0}, '{32'd10, 32'd20, 32'd0, 32'd0},
            -1, 0, 2, 1'b1, 32'd80 + BIAS, 7);

    // Reset in PRES of element 2 of an N=4 run, then a stray result right after.
    a_d = 32'd1; b_d = 32'd1; a_v = 1'b1; b_v = 1'b1;
    cfg_len = 16'd4; start = 1'b1;
    tick();
    start = 1'b0;
    cnt = 0; cyc = 0;
    while (cnt < 2 && cyc < 50) begin
      tick();
      cyc++;
      if (m_macc_tvalid) cnt++;
    end
    chk("r25_pres", 64'(cnt), 64'd2);
    areset = 1'b1; inj = 1'b1;
    #1;
    chk("r25_busy_rst", 64'(busy), 64'd0);
    chk("r25_macvld_rst", 64'(m_macc_tvalid), 64'd0);
    chk("r25_tready_rst", 64'(a_tready), 64'd0);
    tick();
    areset = 1'b0; inj = 1'b0; a_v = 1'b0; b_v = 1'b0;
    chk("r25_idle", 64'(busy), 64'd0);
    tick();
    chk("r25_acc_ignored", 64'(dot_tdata), 64'd0);
    chk("r25_still_idle", 64'(busy), 64'd0);
    run_vec("r25_n1", 1, '{32'd7, 32'd0, 32'd0, 32'd0}, '{32'd3, 32'd0, 32'd0, 32'd0},
            -1, 0, 0, 1'b0, 32'd21 + BIAS, 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dot_seq.md
DOT_SEQ -- requirements
Module: dot_seq

Interface
REQ-001 The block SHALL have one clock, aclk, and one reset, areset; reset is synchronous and active-high.
REQ-002 Parameters SHALL be, one per line:
  BITWIDTH, 32, width of operands, MAC operands and accumulator.
  LEN_WIDTH, 16, width of the vector-length field.
REQ-003 Ports SHALL be, one per line:
  aclk  in  1  clock, all logic on the rising edge.
  areset  in  1  synchronous active-high reset.
  start  in  1  one-cycle pulse that begins a dot product; sampled only in IDLE.
  cfg_len  in  LEN_WIDTH  vector length N; sampled with start.
  busy  out  1  high in every state except IDLE.
  s_axis_a_tdata  in  BITWIDTH  activation element.
  s_axis_a_tvalid  in  1  activation valid.
  s_axis_a_tready  out  1  activation consumed.
  s_axis_b_tdata  in  BITWIDTH  weight element.
  s_axis_b_tvalid  in  1  weight valid.
  s_axis_b_tready  out  1  weight consumed.
  m_macc_a_tdata / m_macc_b_tdata / m_macc_c_tdata  out  BITWIDTH each  operands to the downstream multiply-accumulate unit.
  m_macc_tvalid  out  1  drives all three MAC tvalid inputs.
  s_macc_result_tdata  in  BITWIDTH  MAC result, a*b+c.
  s_macc_result_tvalid  in  1  MAC result valid, returned one cycle after m_macc_tvalid.
  m_axis_dot_tdata  out  BITWIDTH  final dot product.
  m_axis_dot_tvalid  out  1  result valid.
  m_axis_dot_tready  in  1  result accepted.

Function
REQ-004 States SHALL be IDLE, ISSUE, PRES, WAIT and DONE.
REQ-005 IDLE with start=1 SHALL latch cfg_len into len and clear count and acc; it goes to DONE if cfg_len=0, otherwise to ISSUE. start outside IDLE SHALL be ignored.
REQ-006 s_axis_a_tready and s_axis_b_tready SHALL both equal (state==ISSUE) && s_axis_a_tvalid && s_axis_b_tvalid, so both streams transfer together or neither transfers.
REQ-007 On an ISSUE transfer, the block SHALL register a, b and c=acc into m_macc_*_tdata and go to PRES; ISSUE SHALL hold while either tvalid is low.
REQ-008 m_macc_tvalid SHALL be 1 only in PRES, for exactly one cycle per element, and PRES SHALL always go to WAIT.
REQ-009 WAIT SHALL hold until s_macc_result_tvalid=1. On that cycle the block SHALL load acc with s_macc_result_tdata and increment count; it goes to DONE if count+1==len, otherwise to ISSUE.
REQ-010 In DONE, m_axis_dot_tvalid SHALL be 1 with m_axis_dot_tdata=acc, both held stable until m_axis_dot_tready=1, after which the block goes to IDLE on the next edge.
REQ-011 Throughput SHALL be 3 cycles per element with no stalls. Latency SHALL be 3N+1 cycles from the start edge to the first m_axis_dot_tvalid, or 1 cycle for N=0.
REQ-012 All arithmetic SHALL wrap modulo 2^BITWIDTH; the block adds nothing itself and passes the MAC result through unchanged.
REQ-013 s_macc_result_tvalid outside WAIT SHALL be ignored and SHALL NOT modify acc.
REQ-014 m_macc_*_tdata SHALL be 0 whenever m_macc_tvalid=0.

Reset
REQ-015 areset=1 SHALL force state=IDLE and clear len, count, acc and all tdata registers to 0 on the next edge.
REQ-016 While areset=1, all tvalid, all tready and busy SHALL be 0.
REQ-017 Reset mid-operation SHALL discard the partial sum. A MAC result arriving in the cycle after reset SHALL be ignored per REQ-013.

Configuration
REQ-018 The macro DOT_SEQ_BIAS_EN SHALL control the initial accumulator value.
REQ-019 With DOT_SEQ_BIAS_EN defined, an input cfg_bias [BITWIDTH] SHALL exist and SHALL be latched into acc with start; for N=0 the output SHALL equal cfg_bias.
REQ-020 With DOT_SEQ_BIAS_EN undefined, cfg_bias SHALL be absent and acc SHALL start at 0.

Verification
REQ-021 N=3, a={1,2,3}, b={4,5,6}, both streams always valid, ideal 1-cycle MAC -> dot=32, first tvalid 10 cycles after start, m_macc_tvalid pulses exactly 3 times.
REQ-022 N=0 -> dot=0 (or =cfg_bias with DOT_SEQ_BIAS_EN) one cycle after start; no tready and no m_macc_tvalid ever asserted.
REQ-023 N=2, s_axis_b_tvalid low for 5 cycles before element 2 -> neither stream transfers during the gap, a is not consumed alone, dot is correct.
REQ-024 N=2, a=b={0xFFFFFFFF,2}, BITWIDTH=32 -> dot=5 (wrapped); m_axis_dot_tready held low 4 cycles -> tdata and tvalid stable throughout.
REQ-025 areset pulsed in PRES of element 2 of N=4 -> IDLE next cycle, busy=0, the following result is ignored, and a new N=1, a=7, b=3 run gives dot=21.
REQ-026 start pulsed during WAIT and during DONE -> no effect on len, count or result.
